// File: rtl/swap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : swap_sequencer
// Description : Draw-phase sequencer for one player's hand.  Captures the
//               discard decision (swap count plus up to four slot addresses),
//               then, for each discarded slot, fetches one replacement card
//               from the deck dealer over a req/ack handshake and writes it
//               into the 5-slot hand register file.  Reports completion, or
//               a dealer timeout / skipped invalid slot, to the game
//               controller.
//
// Ports       :
//   clk            system clock
//   reset          synchronous active-high reset
//   start          one-cycle pulse, decision inputs valid, begin draw
//   total_swap     number of slots to replace (clamped to MAX_SWAP)
//   swap0..3_addr  slot addresses to replace (valid range 0..4)
//   deck_req       request one card from the dealer
//   deck_ack       dealer strobe, deck_card valid this cycle
//   deck_card      card code {suit[5:4], rank[3:0]}
//   hand_wr_en     one-cycle write strobe to the hand register file
//   hand_wr_addr   slot being written
//   hand_wr_data   replacement card
//   busy           high while a draw is in progress (REQ/WR/FIN)
//   done           one-cycle pulse at the end of a draw
//   error          valid with done: timeout or invalid slot skipped
//   swapped_count  cards actually written, held from done to next start
//
// Revision    : 1.0 - initial release
// ============================================================================
module swap_sequencer #(
  parameter int MAX_SWAP    = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] total_swap,
  input  logic [2:0] swap0_addr,
  input  logic [2:0] swap1_addr,
  input  logic [2:0] swap2_addr,
  input  logic [2:0] swap3_addr,
  output logic       deck_req,
  input  logic       deck_ack,
  input  logic [5:0] deck_card,
  output logic       hand_wr_en,
  output logic [2:0] hand_wr_addr,
  output logic [5:0] hand_wr_data,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] swapped_count
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  // Only four address inputs exist, so the effective limit never exceeds 4.
  localparam int         C_MAX_SWAP  = (MAX_SWAP > 4) ? 4 :
                                       ((MAX_SWAP < 0) ? 0 : MAX_SWAP);
  localparam logic [2:0] C_MAX_N     = 3'(C_MAX_SWAP);
  localparam logic [2:0] C_LAST_SLOT = 3'd4;

  // Timer counts 0..ACK_TIMEOUT-1 while deck_req is high; the last count
  // without an ack is the abort point, giving exactly ACK_TIMEOUT request
  // cycles before giving up.
  localparam int                 C_TMR_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic               C_TMO_EN   = (ACK_TIMEOUT > 0);
  localparam logic [C_TMR_W-1:0] C_TMR_LAST = (ACK_TIMEOUT > 0) ? C_TMR_W'(ACK_TIMEOUT - 1)
                                                                : '0;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [1:0]         state_q, state_d;
  logic [1:0]         idx_q,   idx_d;
  logic [2:0]         n_q,     n_d;
  logic [2:0]         addr_q [4];
  logic [2:0]         addr_d [4];
  logic [5:0]         data_q,  data_d;
  logic [2:0]         cnt_q,   cnt_d;
  logic               err_q,   err_d;
  logic [C_TMR_W-1:0] tmr_q,   tmr_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [2:0] w_start_n;
  logic [2:0] w_cur_addr;
  logic       w_addr_bad;
  logic       w_last;
  logic       w_timeout;

  assign w_start_n  = (total_swap > C_MAX_N) ? C_MAX_N : total_swap;
  assign w_cur_addr = addr_q[idx_q];
  assign w_addr_bad = (w_cur_addr > C_LAST_SLOT);
  // idx is the position of the current slot; it is the final one when
  // idx+1 equals the latched count.
  assign w_last     = (({1'b0, idx_q} + 3'd1) == n_q);
  assign w_timeout  = C_TMO_EN && (tmr_q == C_TMR_LAST);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (w_start_n != 3'd0) ? S_REQ : S_FIN;
        end
      end
      S_REQ: begin
        // An out-of-range slot is skipped without a request, so deck_ack
        // is only honoured when the slot is valid (deck_req high).
        if (w_addr_bad) begin
          if (w_last) begin
            state_d = S_FIN;
          end
        end else if (deck_ack) begin
          state_d = S_WR;
        end else if (w_timeout) begin
          state_d = S_FIN;
        end
      end
      S_WR: begin
        state_d = w_last ? S_FIN : S_REQ;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    deck_req     = 1'b0;
    hand_wr_en   = 1'b0;
    hand_wr_addr = 3'd0;
    hand_wr_data = 6'd0;
    busy         = 1'b0;
    done         = 1'b0;
    error        = 1'b0;
    case (state_q)
      S_REQ: begin
        busy     = 1'b1;
        deck_req = !w_addr_bad;
      end
      S_WR: begin
        busy         = 1'b1;
        hand_wr_en   = 1'b1;
        hand_wr_addr = w_cur_addr;
        hand_wr_data = data_q;
      end
      S_FIN: begin
        busy  = 1'b1;
        done  = 1'b1;
        error = err_q;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Count register drives the port directly so it stays stable after done.
  assign swapped_count = cnt_q;

  // --------------------------------------------------------------------------
  // Datapath: next-value logic
  // --------------------------------------------------------------------------
  always_comb begin
    idx_d  = idx_q;
    n_d    = n_q;
    addr_d = addr_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    tmr_d  = tmr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d[0] = swap0_addr;
          addr_d[1] = swap1_addr;
          addr_d[2] = swap2_addr;
          addr_d[3] = swap3_addr;
          n_d       = w_start_n;
          idx_d     = 2'd0;
          cnt_d     = 3'd0;
          err_d     = 1'b0;
          tmr_d     = '0;
        end
      end
      S_REQ: begin
        if (w_addr_bad) begin
          // Sticky error; move on to the next slot without a deck card.
          err_d = 1'b1;
          tmr_d = '0;
          if (!w_last) begin
            idx_d = idx_q + 2'd1;
          end
        end else if (deck_ack) begin
          data_d = deck_card;
        end else if (w_timeout) begin
          err_d = 1'b1;
          tmr_d = '0;
        end else begin
          tmr_d = tmr_q + C_TMR_W'(1);
        end
      end
      S_WR: begin
        cnt_d = cnt_q + 3'd1;
        tmr_d = '0;
        if (!w_last) begin
          idx_d = idx_q + 2'd1;
        end
      end
      default: begin
        tmr_d = tmr_q;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= 2'd0;
      n_q    <= 3'd0;
      addr_q <= '{default: 3'd0};
      data_q <= 6'd0;
      cnt_q  <= 3'd0;
      err_q  <= 1'b0;
      tmr_q  <= '0;
    end else begin
      idx_q  <= idx_d;
      n_q    <= n_d;
      addr_q <= addr_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      tmr_q  <= tmr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_swap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_swap_sequencer
// Description : Self-checking bench for swap_sequencer.  Each draw is turned
//               into an expected per-cycle output trace derived from the
//               draw rules (slot list, dealer delays, timeout), which also
//               drives the dealer.  One compare process checks every cycle;
//               directed draws add literal expectations on top.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_swap_sequencer;

  localparam int MAXS = 4;
  localparam int TMO  = 16;
  localparam int NOACK = 255;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] total_swap;
  logic [2:0] swap0_addr, swap1_addr, swap2_addr, swap3_addr;
  logic       deck_req;
  logic       deck_ack;
  logic [5:0] deck_card;
  logic       hand_wr_en;
  logic [2:0] hand_wr_addr;
  logic [5:0] hand_wr_data;
  logic       busy, done, error;
  logic [2:0] swapped_count;

  always #5 clk = ~clk;

  swap_sequencer #(
    .MAX_SWAP   (MAXS),
    .ACK_TIMEOUT(TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .total_swap   (total_swap),
    .swap0_addr   (swap0_addr),
    .swap1_addr   (swap1_addr),
    .swap2_addr   (swap2_addr),
    .swap3_addr   (swap3_addr),
    .deck_req     (deck_req),
    .deck_ack     (deck_ack),
    .deck_card    (deck_card),
    .hand_wr_en   (hand_wr_en),
    .hand_wr_addr (hand_wr_addr),
    .hand_wr_data (hand_wr_data),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .swapped_count(swapped_count)
  );

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic       req;
    logic       wr;
    logic [2:0] waddr;
    logic [5:0] wdata;
    logic [2:0] cnt;
  } out_t;

  typedef struct {
    out_t       o;
    logic       ack;
    logic [5:0] card;
  } step_t;

  step_t      q[$];
  out_t       exp_o;
  logic       chk_en = 1'b0;
  int         n_pass = 0;
  int         n_total = 0;
  int         cyc = 0;
  logic [2:0] held_cnt = 3'd0;

  // draw description used by the model
  logic [2:0] m_addr [4];
  int         m_dly  [4];
  logic [5:0] m_card [4];
  int         m_final = 0;

  // DUT event log for the current draw
  int         dut_done_t;
  logic       dut_done_err;
  int         req_cycles;
  int         wr_t[$];
  int         wr_a[$];
  int         wr_d[$];

  function automatic out_t mko(input logic b, input logic d, input logic e,
                               input logic r, input logic w, input logic [2:0] a,
                               input logic [5:0] dat, input int c);
    return {b, d, e, r, w, a, dat, 3'(c)};
  endfunction

  function automatic void push(input out_t o, input logic ack, input logic [5:0] card);
    step_t s;
    s.o = o; s.ack = ack; s.card = card;
    q.push_back(s);
  endfunction

  // Expected trace from the draw rules: per slot either a one-cycle skip,
  // TMO request cycles then abort, or (delay) waiting cycles, an ack cycle
  // and a write cycle; always finished by a done cycle.
  function automatic void build(input int total);
    int n; int cnt; logic err; logic abort;
    n = (total > MAXS) ? MAXS : total;
    cnt = 0; err = 1'b0; abort = 1'b0;
    q.delete();
    for (int i = 0; i < n; i++) begin
      if (!abort) begin
        if (m_addr[i] > 3'd4) begin
          err = 1'b1;
          push(mko(1, 0, 0, 0, 0, 3'd0, 6'd0, cnt), 1'b0, 6'd0);
        end else if (m_dly[i] >= TMO) begin
          for (int k = 0; k < TMO; k++) push(mko(1, 0, 0, 1, 0, 3'd0, 6'd0, cnt), 1'b0, 6'd0);
          err = 1'b1;
          abort = 1'b1;
        end else begin
          for (int k = 0; k < m_dly[i]; k++) push(mko(1, 0, 0, 1, 0, 3'd0, 6'd0, cnt), 1'b0, 6'd0);
          push(mko(1, 0, 0, 1, 0, 3'd0, 6'd0, cnt), 1'b1, m_card[i]);
          push(mko(1, 0, 0, 0, 1, m_addr[i], m_card[i], cnt), 1'b0, 6'd0);
          cnt++;
        end
      end
    end
    push(mko(1, 1, err, 0, 0, 3'd0, 6'd0, cnt), 1'b0, 6'd0);
    m_final = cnt;
  endfunction

  // single per-cycle compare process
  always @(negedge clk) begin
    if (chk_en) begin
      out_t act;
      act = {busy, done, error, deck_req, hand_wr_en, hand_wr_addr, hand_wr_data, swapped_count};
      n_total++;
      if (act === exp_o) begin
        n_pass++;
      end else begin
        $display("FAIL cycle t=%0d: got busy/done/err/req/wr/addr/data/cnt=%b/%b/%b/%b/%b/%0d/%h/%0d required %b/%b/%b/%b/%b/%0d/%h/%0d",
                 cyc, act.busy, act.done, act.err, act.req, act.wr, act.waddr, act.wdata, act.cnt,
                 exp_o.busy, exp_o.done, exp_o.err, exp_o.req, exp_o.wr, exp_o.waddr, exp_o.wdata, exp_o.cnt);
      end
      if (done) begin
        dut_done_t   = cyc;
        dut_done_err = error;
      end
      if (deck_req) req_cycles++;
      if (hand_wr_en) begin
        wr_t.push_back(cyc);
        wr_a.push_back(int'(hand_wr_addr));
        wr_d.push_back(int'(hand_wr_data));
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, req);
  endtask

  function automatic int qget(input int which, input int k);
    if (which == 0) return (k < wr_t.size()) ? wr_t[k] : -1;
    if (which == 1) return (k < wr_a.size()) ? wr_a[k] : -1;
    return (k < wr_d.size()) ? wr_d[k] : -1;
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start     = 1'b0;
      deck_ack  = 1'($urandom_range(0, 1));
      deck_card = 6'($urandom);
      cyc++;
      exp_o = mko(0, 0, 0, 0, 0, 3'd0, 6'd0, int'(held_cnt));
    end
  endtask

  // Runs one draw. glitch_at: trace index with an extra start pulse (-1 none).
  // reset_at: trace index during which reset is asserted (-1 none).
  task automatic run_draw(input int total, input int glitch_at, input int reset_at);
    int last;
    build(total);
    @(posedge clk); #1;
    total_swap = 3'(total);
    swap0_addr = m_addr[0]; swap1_addr = m_addr[1];
    swap2_addr = m_addr[2]; swap3_addr = m_addr[3];
    start    = 1'b1;
    deck_ack = 1'b0;
    cyc      = 0;
    exp_o    = mko(0, 0, 0, 0, 0, 3'd0, 6'd0, int'(held_cnt));
    dut_done_t = -1; dut_done_err = 1'b0; req_cycles = 0;
    wr_t.delete(); wr_a.delete(); wr_d.delete();
    chk_en = 1'b1;
    last = (reset_at >= 0) ? reset_at : q.size() - 1;
    for (int i = 0; i <= last; i++) begin
      @(posedge clk); #1;
      cyc   = i + 1;
      start = (i == glitch_at);
      if (i == glitch_at) begin
        total_swap = 3'($urandom); swap0_addr = 3'($urandom); swap1_addr = 3'($urandom);
        swap2_addr = 3'($urandom); swap3_addr = 3'($urandom);
      end
      exp_o     = q[i].o;
      deck_ack  = q[i].ack;
      deck_card = q[i].ack ? q[i].card : 6'($urandom);
      if (i == reset_at) begin
        reset    = 1'b1;
        deck_ack = 1'b0;
      end
    end
    if (reset_at >= 0) begin
      @(posedge clk); #1;
      reset    = 1'b0;
      cyc++;
      held_cnt = 3'd0;
      exp_o    = mko(0, 0, 0, 0, 0, 3'd0, 6'd0, 0);
    end else begin
      held_cnt = 3'(m_final);
    end
    idle_cycles(4);
  endtask

  task automatic set_draw(input int a0, input int a1, input int a2, input int a3,
                          input int d0, input int d1, input int d2, input int d3,
                          input int c0, input int c1, input int c2, input int c3);
    m_addr[0] = 3'(a0); m_addr[1] = 3'(a1); m_addr[2] = 3'(a2); m_addr[3] = 3'(a3);
    m_dly[0] = d0; m_dly[1] = d1; m_dly[2] = d2; m_dly[3] = d3;
    m_card[0] = 6'(c0); m_card[1] = 6'(c1); m_card[2] = 6'(c2); m_card[3] = 6'(c3);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; total_swap = 3'd0; deck_ack = 1'b0; deck_card = 6'd0;
    swap0_addr = 3'd0; swap1_addr = 3'd0; swap2_addr = 3'd0; swap3_addr = 3'd0;
    exp_o = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("reset_outputs",
          int'({busy, done, error, deck_req, hand_wr_en, hand_wr_addr, hand_wr_data, swapped_count}), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_cycles(3);

    // 1: three immediate acks
    set_draw(0, 1, 4, 0, 0, 0, 0, 0, 'h05, 'h2A, 'h33, 0);
    run_draw(3, -1, -1);
    check("t1_model_len", q.size(), 7);
    check("t1_done_cycle", dut_done_t, 7);
    check("t1_error", int'(dut_done_err), 0);
    check("t1_count", int'(swapped_count), 3);
    check("t1_wr0_cycle", qget(0, 0), 2);
    check("t1_wr0_addr", qget(1, 0), 0);
    check("t1_wr0_data", qget(2, 0), 'h05);
    check("t1_wr1_cycle", qget(0, 1), 4);
    check("t1_wr1_data", qget(2, 1), 'h2A);
    check("t1_wr2_cycle", qget(0, 2), 6);
    check("t1_wr2_addr", qget(1, 2), 4);
    check("t1_wr2_data", qget(2, 2), 'h33);

    // 2: nothing to swap
    run_draw(0, -1, -1);
    check("t2_done_cycle", dut_done_t, 1);
    check("t2_req_cycles", req_cycles, 0);
    check("t2_writes", wr_t.size(), 0);
    check("t2_count", int'(swapped_count), 0);

    // 3: dealer delays each ack by 5 cycles
    set_draw(3, 4, 0, 0, 5, 5, 0, 0, 'h11, 'h22, 0, 0);
    run_draw(2, -1, -1);
    check("t3_req_cycles", req_cycles, 12);
    check("t3_writes", wr_t.size(), 2);
    check("t3_done_cycle", dut_done_t, 15);
    check("t3_error", int'(dut_done_err), 0);

    // 4: dealer never acks
    set_draw(2, 0, 0, 0, NOACK, 0, 0, 0, 0, 0, 0, 0);
    run_draw(1, -1, -1);
    check("t4_req_cycles", req_cycles, 16);
    check("t4_writes", wr_t.size(), 0);
    check("t4_error", int'(dut_done_err), 1);
    check("t4_done_cycle", dut_done_t, 17);
    check("t4_count", int'(swapped_count), 0);

    // 5: clamp to four, extra start mid-draw
    set_draw(0, 1, 2, 3, 0, 0, 0, 0, 'h01, 'h12, 'h23, 'h34);
    run_draw(6, 2, -1);
    check("t5_writes", wr_t.size(), 4);
    check("t5_count", int'(swapped_count), 4);
    check("t5_done_cycle", dut_done_t, 9);

    // 6: invalid slot skipped, then reset mid-draw
    set_draw(7, 2, 0, 0, 0, 0, 0, 0, 'h3F, 'h2C, 0, 0);
    run_draw(2, -1, -1);
    check("t6_req_cycles", req_cycles, 1);
    check("t6_error", int'(dut_done_err), 1);
    check("t6_count", int'(swapped_count), 1);
    check("t6_wr_addr", qget(1, 0), 2);
    set_draw(0, 1, 2, 0, 3, 3, 3, 0, 'h05, 'h06, 'h07, 0);
    run_draw(3, -1, 1);
    check("t6_abort_no_done", dut_done_t, -1);

    // randomized draws
    for (int r = 0; r < 40; r++) begin
      int tot; int g;
      for (int s = 0; s < 4; s++) begin
        m_addr[s] = ($urandom_range(0, 99) < 85) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
        m_dly[s]  = ($urandom_range(0, 99) < 8) ? NOACK : int'($urandom_range(0, 6));
        m_card[s] = 6'($urandom);
      end
      tot = int'($urandom_range(0, 7));
      build(tot);
      g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, q.size() - 1)) : -1;
      run_draw(tot, g, -1);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
